// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - line-granular main-memory controller on bus 2
// Serves cache line reads/writes with fixed latency and little-endian multi-beat bursts.
module mem_ctrl #(
  parameter int ADDR2_BUS_SIZE  = 14,
  parameter int DATA2_BUS_SIZE  = 16,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int MEM_LATENCY     = 100
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR2_BUS_SIZE-1:0] A2_IN,
  input  logic [DATA2_BUS_SIZE-1:0] D2_IN,
  input  logic [1:0]                C2_IN,
  output logic [DATA2_BUS_SIZE-1:0] D2_OUT,
  output logic [1:0]                C2_OUT,
  output logic                      D2_OE,
  output logic                      C2_OE
);

  localparam int DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE / 8;
  localparam int BEATS  = CACHE_LINE_SIZE / DATA2_BUS_SIZE_BYTES;
  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam int DEPTH  = 1 << ADDR2_BUS_SIZE;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_RX  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RD_TX  = 3'd3;
  localparam logic [2:0] S_WR_ACK = 3'd4;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] FIRST_NEXT = (BEATS > 1) ? BEAT_W'(1) : '0;
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);

  logic [2:0]                state_q, state_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  logic                      is_wr_q, is_wr_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [LINE_W-1:0]         wr_buf_q, wr_buf_d;
  logic [LINE_W-1:0]         rd_line_q, rd_line_d;
  logic [1:0]                c2_out_q, c2_out_d;
  logic [DATA2_BUS_SIZE-1:0] d2_out_q, d2_out_d;
  logic                      c2_oe_q, c2_oe_d;
  logic                      d2_oe_q, d2_oe_d;
  logic                      mem_we;
  logic [LINE_W-1:0]         mem_line;
  int                        beat_idx;

  logic [LINE_W-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    wr_buf_d  = wr_buf_q;
    rd_line_d = rd_line_q;
    c2_out_d  = c2_out_q;
    d2_out_d  = d2_out_q;
    c2_oe_d   = c2_oe_q;
    d2_oe_d   = d2_oe_q;
    mem_we    = 1'b0;
    mem_line  = mem[addr_q];
    beat_idx  = int'(beat_q) * DATA2_BUS_SIZE;

    case (state_q)
      S_IDLE: begin
        c2_oe_d  = 1'b0;
        d2_oe_d  = 1'b0;
        c2_out_d = C2_NOP;
        d2_out_d = '0;
        if (C2_IN == C2_READ_LINE || C2_IN == C2_WRITE_LINE) begin
          addr_d  = A2_IN;
          is_wr_d = (C2_IN == C2_WRITE_LINE);
          lat_d   = LAT_LOAD;
          beat_d  = '0;
          state_d = S_WAIT;
          if (C2_IN == C2_WRITE_LINE) begin
            wr_buf_d                       = '0;
            wr_buf_d[DATA2_BUS_SIZE-1:0]   = D2_IN;
            if (BEATS == 1) begin
              mem_we = 1'b1;
            end else begin
              beat_d  = FIRST_NEXT;
              state_d = S_WR_RX;
            end
          end
        end
      end
      S_WR_RX: begin
        // The last beat merges with the buffer so the whole line lands in one write.
        wr_buf_d[beat_idx +: DATA2_BUS_SIZE] = D2_IN;
        lat_d  = lat_q - 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          mem_we  = 1'b1;
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        c2_oe_d  = 1'b1;
        c2_out_d = C2_NOP;
        if (lat_q == '0) begin
          c2_out_d = C2_RESPONSE;
          if (is_wr_q) begin
            state_d = S_WR_ACK;
          end else begin
            rd_line_d = mem_line;
            d2_out_d  = mem_line[DATA2_BUS_SIZE-1:0];
            d2_oe_d   = 1'b1;
            beat_d    = FIRST_NEXT;
            state_d   = S_RD_TX;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RD_TX: begin
        // beat_q wrapping to zero marks that the final beat is already on the bus.
        if (beat_q == '0) begin
          c2_oe_d  = 1'b0;
          d2_oe_d  = 1'b0;
          c2_out_d = C2_NOP;
          d2_out_d = '0;
          state_d  = S_IDLE;
        end else begin
          d2_out_d = rd_line_q[beat_idx +: DATA2_BUS_SIZE];
          beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
      end
      S_WR_ACK: begin
        c2_oe_d  = 1'b0;
        c2_out_d = C2_NOP;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      lat_q     <= '0;
      beat_q    <= '0;
      wr_buf_q  <= '0;
      rd_line_q <= '0;
      c2_out_q  <= C2_NOP;
      d2_out_q  <= '0;
      c2_oe_q   <= 1'b0;
      d2_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      wr_buf_q  <= wr_buf_d;
      rd_line_q <= rd_line_d;
      c2_out_q  <= c2_out_d;
      d2_out_q  <= d2_out_d;
      c2_oe_q   <= c2_oe_d;
      d2_oe_q   <= d2_oe_d;
    end
  end

  // Array contents survive reset; only the commit strobe is gated by it.
  always_ff @(posedge CLK) begin
    if (RESET && mem_we) begin
      mem[addr_d] <= wr_buf_d;
    end
  end

  assign D2_OUT = d2_out_q;
  assign C2_OUT = c2_out_q;
  assign D2_OE  = d2_oe_q;
  assign C2_OE  = c2_oe_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed scoreboard bench for mem_ctrl
module tb_mem_ctrl;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int LINEB = 16;
  localparam int LAT   = 100;
  localparam int BEATS = 8;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] A2_IN;
  logic [DW-1:0] D2_IN;
  logic [1:0]    C2_IN;
  logic [DW-1:0] D2_OUT;
  logic [1:0]    C2_OUT;
  logic          D2_OE;
  logic          C2_OE;

  always #5 CLK = ~CLK;

  mem_ctrl #(
    .ADDR2_BUS_SIZE (AW),
    .DATA2_BUS_SIZE (DW),
    .CACHE_LINE_SIZE(LINEB),
    .MEM_LATENCY    (LAT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .A2_IN (A2_IN),
    .D2_IN (D2_IN),
    .C2_IN (C2_IN),
    .D2_OUT(D2_OUT),
    .C2_OUT(C2_OUT),
    .D2_OE (D2_OE),
    .C2_OE (C2_OE)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] model [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'({C2_OE, D2_OE, C2_OUT, D2_OUT}), 32'd0);
  endtask

  function automatic logic [127:0] mk_line(input logic [7:0] seed, input logic [7:0] step);
    logic [127:0] l;
    logic [7:0]   b;
    b = seed;
    for (int i = 0; i < LINEB; i++) begin
      l[i*8 +: 8] = b;
      b = b + step;
    end
    return l;
  endfunction

  task automatic hold_reset(input string tag);
    RESET = 1'b0;
    #1;
    chk_quiet(tag);
    repeat (3) @(negedge CLK);
    C2_IN = C2_NOP;
    D2_IN = '0;
    RESET = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [127:0] line, input int rst_at);
    int n;
    bit bad;
    @(negedge CLK);
    C2_IN = C2_WRITE_LINE;
    A2_IN = addr;
    D2_IN = line[DW-1:0];
    for (int j = 1; j < BEATS; j++) begin
      @(negedge CLK);
      C2_IN = C2_NOP;
      if (rst_at == j) begin
        hold_reset("wr_rx_reset_outputs");
        return;
      end
      D2_IN = line[j*DW +: DW];
    end
    @(negedge CLK);
    D2_IN = '0;
    n = BEATS - 1;
    model[addr] = line;
    chk("wr_oe_at_commit", 32'(C2_OE), 32'd0);
    bad = 1'b0;
    while (1) begin
      @(negedge CLK);
      n++;
      if (C2_OUT === C2_RESPONSE || n >= 2 * LAT) break;
      bad = bad | !(C2_OE === 1'b1 && D2_OE === 1'b0 && C2_OUT === C2_NOP);
    end
    chk("wr_wait_own", 32'(bad), 32'd0);
    chk("wr_latency", 32'(n), 32'(LAT));
    chk("wr_resp_own", 32'({C2_OE, D2_OE}), 32'b10);
    @(negedge CLK);
    chk("wr_release", 32'({C2_OE, D2_OE, C2_OUT}), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input bit inject, input bit abort);
    int n;
    bit bad;
    logic [DW-1:0] e;
    for (int b = 0; b < BEATS; b++) exp_q.push_back(model[addr][b*DW +: DW]);
    @(negedge CLK);
    C2_IN = C2_READ_LINE;
    A2_IN = addr;
    @(negedge CLK);
    C2_IN = C2_NOP;
    n = 0;
    bad = 1'b0;
    while (1) begin
      @(negedge CLK);
      n++;
      if (inject && n == 10) begin
        C2_IN = C2_READ_LINE;
        A2_IN = '0;
      end else begin
        C2_IN = C2_NOP;
      end
      if (C2_OUT === C2_RESPONSE || n >= 2 * LAT) break;
      bad = bad | !(C2_OE === 1'b1 && D2_OE === 1'b0 && C2_OUT === C2_NOP);
    end
    chk("rd_wait_own", 32'(bad), 32'd0);
    chk("rd_latency", 32'(n), 32'(LAT));
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) @(negedge CLK);
      chk("rd_beat_own", 32'({C2_OE, D2_OE, C2_OUT}), 32'({1'b1, 1'b1, C2_RESPONSE}));
      e = exp_q.pop_front();
      chk("rd_beat_data", 32'(D2_OUT), 32'(e));
      if (abort && b == 2) begin
        exp_q.delete();
        hold_reset("rd_tx_reset_outputs");
        return;
      end
    end
    @(negedge CLK);
    chk_quiet("rd_release");
    if (inject) begin
      bad = 1'b0;
      repeat (2 * LAT) begin
        @(negedge CLK);
        bad = bad | (C2_OE !== 1'b0) | (C2_OUT !== C2_NOP);
      end
      chk("no_extra_response", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit bad;
    logic [127:0] line_a;
    logic [127:0] line_b;
    RESET = 1'b0;
    C2_IN = C2_NOP;
    A2_IN = '0;
    D2_IN = '0;
    repeat (2) @(negedge CLK);
    chk_quiet("reset_state");
    RESET = 1'b1;

    line_a = mk_line(8'hA0, 8'h03);
    line_b = mk_line(8'h50, 8'h11);
    do_write(14'h0005, line_a, 0);
    do_read(14'h0005, 1'b0, 1'b0);
    do_write(14'h0005, line_b, 4);
    do_read(14'h0005, 1'b0, 1'b0);

    do_write(14'h0123, mk_line(8'h00, 8'h01), 0);
    do_read(14'h0123, 1'b0, 1'b0);

    @(negedge CLK);
    C2_IN = C2_RESPONSE;
    A2_IN = 14'h0123;
    @(negedge CLK);
    C2_IN = C2_NOP;
    bad = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      bad = bad | (C2_OE !== 1'b0) | (C2_OUT !== C2_NOP);
    end
    chk("ignored_response_cmd", 32'(bad), 32'd0);
    do_read(14'h0123, 1'b1, 1'b0);

    do_write(14'h0000, mk_line(8'h11, 8'h05), 0);
    do_write(14'h3FFF, mk_line(8'hF0, 8'hFD), 0);
    do_read(14'h0000, 1'b0, 1'b0);
    do_read(14'h3FFF, 1'b0, 1'b0);

    do_read(14'h3FFF, 1'b0, 1'b1);
    do_read(14'h0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Line-granular main-memory controller on bus 2, directly downstream of the cache.
- Serves cache C2_READ_LINE and C2_WRITE_LINE commands with a fixed access latency.
- Transfers a line as little-endian multi-beat bursts over D2.
- Bus 2 uses split in/out signals plus output enables; the top level resolves the tri-state.

Parameters:
- ADDR2_BUS_SIZE, 14: line address width (tag+set); memory holds 2^ADDR2_BUS_SIZE lines.
- DATA2_BUS_SIZE, 16: D2 width in bits; must be a multiple of 8; DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE/8.
- CACHE_LINE_SIZE, 16: line size in bytes; BEATS = CACHE_LINE_SIZE/DATA2_BUS_SIZE_BYTES (default 8).
- MEM_LATENCY, 100: cycles from command edge to first response; must be >= BEATS+1.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset.
- A2_IN  in  ADDR2_BUS_SIZE  line address from cache; valid in the command cycle.
- D2_IN  in  DATA2_BUS_SIZE  write beats from cache.
- C2_IN  in  2  command from cache: 0=C2_NOP, 1=C2_RESPONSE, 2=C2_READ_LINE, 3=C2_WRITE_LINE.
- D2_OUT  out  DATA2_BUS_SIZE  read beats to cache.
- C2_OUT  out  2  memory-side command: C2_NOP or C2_RESPONSE.
- D2_OE  out  1  memory drives D2.
- C2_OE  out  1  memory drives C2 (bus owned by memory).

Behaviour:
- Reset (RESET low, async): FSM=IDLE; C2_OUT=C2_NOP; D2_OUT=0; C2_OE=0; D2_OE=0; latency and beat counters=0; write buffer discarded. Memory array is not cleared.
- Command edge k:
  - In IDLE, sample C2_IN at posedge k.
  - READ_LINE or WRITE_LINE latches A2_IN.
  - C2_NOP, C2_RESPONSE and all commands outside IDLE are ignored.
- Beat order: beat j carries bytes j*B .. j*B+B-1, where B=DATA2_BUS_SIZE_BYTES. Byte j*B sits in D2[7:0], byte j*B+1 in D2[15:8], and so on.
- States: IDLE, WR_RX, WAIT, RD_TX, WR_ACK.
- Write:
  - Beat 0 is D2_IN at edge k; WR_RX collects beats 1..BEATS-1 at edges k+1..k+BEATS-1.
  - The full line commits to the array atomically at edge k+BEATS-1, then go to WAIT.
  - From edge k+BEATS: C2_OE=1, C2_OUT=C2_NOP.
  - Edge k+MEM_LATENCY (WR_ACK): C2_OUT=C2_RESPONSE for exactly one cycle.
  - Next edge: C2_OE=0, return to IDLE.
  - D2_OE stays 0 throughout.
- Read:
  - From edge k+1: C2_OE=1, C2_OUT=C2_NOP (WAIT).
  - Edges k+MEM_LATENCY .. k+MEM_LATENCY+BEATS-1 (RD_TX): C2_OUT=C2_RESPONSE, D2_OE=1, D2_OUT=beat 0..BEATS-1.
  - Following edge: C2_OE=0, D2_OE=0, D2_OUT=0, return to IDLE.
  - Total bus occupancy is MEM_LATENCY+BEATS cycles after the command edge.
- Latency counter: loaded at edge k, counts edges to k+MEM_LATENCY; width $clog2(MEM_LATENCY+1).
- Beat counter: $clog2(BEATS) bits; wraps to 0 at end of burst.
- Read data is sampled from the array when RD_TX starts. A read issued after a write's C2_RESPONSE returns the new data.
- Reset mid-operation:
  - During WR_RX (before the commit edge): array unchanged.
  - After the commit edge: write persists.
  - In all cases, outputs return to reset values immediately.
- Back-to-back: a new command is accepted no earlier than the edge after returning to IDLE. C2_IN on the release edge is ignored.
- Addresses: full ADDR2_BUS_SIZE range is valid; no wrap or aliasing.

Test Plan:
- Reset mid-WR_RX: WRITE_LINE to 0x0005, drop RESET low after beat 3 -> outputs reset immediately. Later READ_LINE 0x0005 returns prior contents.
- Write then read: WRITE_LINE A2=0x0123, bytes 0x00..0x0F (beats 0x0100, 0x0302, ...) -> C2_RESPONSE one cycle at edge k+100. READ_LINE 0x0123 -> 8 beats 0x0100, 0x0302 .. 0x0F0E at edges k'+100 .. k'+107.
- Ownership timing on read: C2_OE=1 from k+1 to k+107 with C2_NOP until k+99. D2_OE high only k+100 .. k+107. Both 0 at k+108.
- Ignored commands: C2_IN=C2_RESPONSE in IDLE, and READ_LINE issued during WAIT -> no state change, no extra response.
- Address extremes: write distinct lines at 0x0000 and 0x3FFF, read both back -> no aliasing, correct data.
